// File: rtl/btn_evt_pkg.sv
// Shared encodings for the button event controller.
// Event types and arbiter state enum.
package btn_evt_pkg;

    localparam logic EVT_RELEASE = 1'b0;
    localparam logic EVT_PRESS   = 1'b1;

    typedef enum logic {
        ARB_IDLE,
        ARB_OFFER
    } arb_state_t;

endpackage

// File: rtl/btn_rr_arbiter.sv
// Combinational round-robin pick over the pending event slots.
// Search starts at the index after last_grant and wraps.
module btn_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [IDW-1:0] grant,
    output logic           any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = last_grant;
        for (int k = 0; k < N; k++) begin
            idx = (idx == IDW'(N - 1)) ? '0 : idx + IDW'(1);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/button_event_controller.sv
// Debounced button front end: sync, tick-sampled filter, per-button
// pending slot and a round-robin serialiser onto one event port.
module button_event_controller
    import btn_evt_pkg::*;
#(
    parameter int NUM_BTNS     = 4,
    parameter int SAMPLE_DIV   = 4096,
    parameter int STABLE_TICKS = 16,
    localparam int IDW = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDW-1:0]      evt_id,
    output logic                evt_type,
    output logic                evt_ovf,
    input  logic                ovf_clr
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);

    logic [NUM_BTNS-1:0] sync1, sync2;
    logic [NUM_BTNS-1:0] ev_new, ev_type;
    logic [NUM_BTNS-1:0] pend_v, pend_t, grant_oh;
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [SW-1:0]       stab_cnt [NUM_BTNS];
    logic [IDW-1:0]      last_grant, grant_idx;
    logic                grant_any, arb_load, ovf_set;
    arb_state_t          state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TW'(1);
    end

    always_comb begin
        ev_new  = '0;
        ev_type = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            ev_type[i] = sync2[i] ? EVT_PRESS : EVT_RELEASE;
            ev_new[i]  = tick && (sync2[i] != btn_state[i]) &&
                         (stab_cnt[i] >= SW'(STABLE_TICKS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_state <= '0;
            for (int i = 0; i < NUM_BTNS; i++) stab_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync2[i] == btn_state[i]) begin
                    stab_cnt[i] <= '0;
                end else if (ev_new[i]) begin
                    btn_state[i] <= sync2[i];
                    stab_cnt[i]  <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + SW'(1);
                end
            end
        end
    end

    // A slot being granted this cycle is free again, so a new event there is no overwrite.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_BTNS; i++)
            grant_oh[i] = arb_load && (grant_idx == IDW'(i));
    end

    assign ovf_set = |(ev_new & pend_v & ~grant_oh);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v <= '0;
            pend_t <= '0;
        end else begin
            pend_v <= (pend_v & ~grant_oh) | ev_new;
            pend_t <= (pend_t & ~ev_new) | (ev_type & ev_new);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        evt_ovf <= 1'b0;
        else if (ovf_set) evt_ovf <= 1'b1;
        else if (ovf_clr) evt_ovf <= 1'b0;
    end

    btn_rr_arbiter #(
        .N   (NUM_BTNS),
        .IDW (IDW)
    ) u_arb (
        .req        (pend_v),
        .last_grant (last_grant),
        .grant      (grant_idx),
        .any        (grant_any)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arb_load  = 1'b0;
        evt_valid = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (grant_any) begin
                    arb_load  = 1'b1;
                    state_nxt = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                evt_valid = 1'b1;
                if (evt_ready) state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_id     <= '0;
            evt_type   <= 1'b0;
            last_grant <= IDW'(NUM_BTNS - 1);
        end else if (arb_load) begin
            evt_id     <= grant_idx;
            evt_type   <= pend_t[grant_idx];
            last_grant <= grant_idx;
        end
    end

endmodule

// File: tb/tb_button_event_controller.sv
// Scoreboard bench: per-button expected event queues fed by the stimulus,
// drained by an independent monitor on every accepted event.
module tb_button_event_controller;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int ST  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic         evt_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [N-1:0] btn_state;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic         evt_type;
    logic         evt_ovf;

    int checks = 0;
    int errors = 0;

    bit exp_q [N][$];
    int obs_q [$];

    typedef struct {
        bit lvl;
        int dur;
        bit ev;
    } seg_t;

    seg_t seg_q [N][$];

    button_event_controller #(
        .NUM_BTNS     (N),
        .SAMPLE_DIV   (DIV),
        .STABLE_TICKS (ST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_state (btn_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int obs_at(input int i);
        return (obs_q.size() > i) ? obs_q[i] : -1;
    endfunction

    // Monitor: every accepted event must match the oldest expected one for its button.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            obs_q.push_back(int'(evt_id));
            if (exp_q[evt_id].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected: got id=%0d type=%0d expected none",
                         evt_id, evt_type);
            end else begin
                chk("evt_type", 32'(evt_type), 32'(exp_q[evt_id].pop_front()));
            end
        end
    end

    bit           cur [N];
    int           left [N];
    int           lat;
    bit           busy;
    seg_t         s;
    logic [N-1:0] fin;

    initial begin
        // reset with all buttons held
        reset  = 1'b1;
        btn_in = '1;
        step(5);
        @(negedge clk);
        chk("rst_btn_state", 32'(btn_state), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_id", 32'(evt_id), 0);
        chk("rst_evt_type", 32'(evt_type), 0);
        chk("rst_evt_ovf", 32'(evt_ovf), 0);
        step(1);
        reset     = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b1;
        repeat (2) begin
            step(1);
            @(negedge clk);
            chk("post_rst_valid", 32'(evt_valid), 0);
        end

        // single press / release with latency bound
        step(1);
        btn_in[0] = 1'b1;
        exp_q[0].push_back(1'b1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            @(negedge clk);
            if (btn_state[0] && lat < 0) lat = k;
        end
        chk("press_latency_le14", 32'(lat >= 1 && lat <= 14), 1);
        step(10);
        btn_in[0] = 1'b0;
        exp_q[0].push_back(1'b0);
        step(25);
        @(negedge clk);
        chk("release_state", 32'(btn_state), 0);

        // short pulses must be filtered
        step(1);
        repeat (5) begin
            btn_in[2] = 1'b1;
            step(8);
            btn_in[2] = 1'b0;
            step(8);
        end
        step(10);
        @(negedge clk);
        chk("glitch_state", 32'(btn_state), 0);

        // round-robin order
        step(1);
        obs_q.delete();
        btn_in = 4'b1010;
        exp_q[1].push_back(1'b1);
        exp_q[3].push_back(1'b1);
        step(30);
        chk("rr_a_count", 32'(obs_q.size()), 2);
        chk("rr_a_first", 32'(obs_at(0)), 1);
        chk("rr_a_second", 32'(obs_at(1)), 3);
        obs_q.delete();
        btn_in = 4'b1111;
        exp_q[0].push_back(1'b1);
        exp_q[2].push_back(1'b1);
        step(30);
        chk("rr_b_count", 32'(obs_q.size()), 2);
        chk("rr_b_first", 32'(obs_at(0)), 0);
        chk("rr_b_second", 32'(obs_at(1)), 2);
        btn_in = '0;
        for (int b = 0; b < N; b++) exp_q[b].push_back(1'b0);
        step(40);
        @(negedge clk);
        chk("all_released", 32'(btn_state), 0);

        // overflow while the consumer stalls
        step(1);
        evt_ready = 1'b0;
        btn_in[0] = 1'b1;
        exp_q[0].push_back(1'b1);
        step(20);
        @(negedge clk);
        chk("stall_valid", 32'(evt_valid), 1);
        chk("stall_id", 32'(evt_id), 0);
        chk("stall_type", 32'(evt_type), 1);
        step(1);
        btn_in[0] = 1'b0;
        step(20);
        btn_in[0] = 1'b1;
        step(20);
        @(negedge clk);
        chk("held_id", 32'(evt_id), 0);
        chk("held_type", 32'(evt_type), 1);
        chk("held_valid", 32'(evt_valid), 1);
        chk("ovf_set", 32'(evt_ovf), 1);
        step(1);
        exp_q[0].push_back(1'b1);
        evt_ready = 1'b1;
        step(10);
        @(negedge clk);
        chk("ovf_sticky", 32'(evt_ovf), 1);
        chk("ovf_drained", 32'(exp_q[0].size()), 0);
        step(1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(evt_ovf), 0);

        // randomised level segments per button
        step(1);
        btn_in[0] = 1'b0;
        exp_q[0].push_back(1'b0);
        step(30);
        for (int b = 0; b < N; b++) begin
            cur[b]  = 1'b0;
            left[b] = 0;
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(2, 0) == 0) begin
                    seg_q[b].push_back('{~cur[b], int'($urandom_range(8, 1)), 1'b0});
                    seg_q[b].push_back('{cur[b], int'($urandom_range(12, 5)), 1'b0});
                end else begin
                    cur[b] = ~cur[b];
                    seg_q[b].push_back('{cur[b], int'($urandom_range(40, 18)), 1'b1});
                end
            end
        end
        busy = 1'b1;
        while (busy) begin
            busy = 1'b0;
            for (int b = 0; b < N; b++) begin
                if (left[b] == 0 && seg_q[b].size() > 0) begin
                    s = seg_q[b].pop_front();
                    btn_in[b] = s.lvl;
                    left[b]   = s.dur;
                    if (s.ev) exp_q[b].push_back(s.lvl);
                end
                if (left[b] > 0) begin
                    left[b]--;
                    busy = 1'b1;
                end
            end
            step(1);
        end
        step(40);
        for (int b = 0; b < N; b++) fin[b] = cur[b];
        @(negedge clk);
        chk("rand_final_state", 32'(btn_state), 32'(fin));
        chk("rand_no_ovf", 32'(evt_ovf), 0);
        for (int b = 0; b < N; b++)
            chk("rand_queue_empty", 32'(exp_q[b].size()), 0);

        // reset while an event is offered and others are pending
        step(1);
        btn_in = '0;
        for (int b = 0; b < N; b++) if (cur[b]) exp_q[b].push_back(1'b0);
        step(40);
        evt_ready = 1'b0;
        btn_in    = 4'b1110;
        for (int b = 1; b < N; b++) exp_q[b].push_back(1'b1);
        step(20);
        @(negedge clk);
        chk("pre_rst_valid", 32'(evt_valid), 1);
        step(1);
        reset  = 1'b1;
        btn_in = '0;
        for (int b = 0; b < N; b++) exp_q[b].delete();
        step(1);
        @(negedge clk);
        chk("rst_drops_valid", 32'(evt_valid), 0);
        step(2);
        reset     = 1'b0;
        evt_ready = 1'b1;
        step(40);
        @(negedge clk);
        chk("post_rst_state", 32'(btn_state), 0);
        chk("post_rst_idle", 32'(evt_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
